// File: rtl/lstm_cell_seq.sv
// Sequential single-cell LSTM: streams x then h elements into four gate accumulators,
// then computes the hard activations, the cell state and the hidden output. Optional macro LSTM_CELL_SEQ_SAT_EN.
module lstm_cell_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int NUM_X = 4,
  parameter int NUM_H = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_clr_state,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [4*WIDTH-1:0] i_w,
  input  logic [4*WIDTH-1:0] i_b,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_valid,
  output logic [4*WIDTH-1:0] o_gate,
  output logic [WIDTH-1:0]   o_c,
  output logic [WIDTH-1:0]   o_h
);

  localparam int TOTAL = NUM_X + NUM_H;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [WIDTH-1:0] HALF    = ONE >>> 1;
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
  localparam logic signed [WIDTH-1:0] ZERO    = '0;

  typedef enum logic [2:0] {IDLE, ACC, ACT, CELL, DONE} state_t;

  state_t state, next_state;

  logic signed [WIDTH-1:0] acc [4];
  logic signed [WIDTH-1:0] gate [4];
  logic signed [WIDTH-1:0] c_prev;
  logic signed [WIDTH-1:0] c_new;
  logic signed [WIDTH-1:0] h_new;
  logic [CW-1:0]           cnt;

  // Accumulator and cell-state additions either saturate or wrap, depending on the build.
  function automatic logic signed [WIDTH-1:0] add_w(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
`ifdef LSTM_CELL_SEQ_SAT_EN
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      add_w = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      add_w = s[WIDTH-1:0];
`else
    add_w = a + b;
`endif
  endfunction

  function automatic logic signed [WIDTH-1:0] mul_q(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    p = p >>> FRAC;
    mul_q = p[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] x,
                                                   input logic signed [WIDTH-1:0] lo,
                                                   input logic signed [WIDTH-1:0] hi);
    if (x < lo)      clamp = lo;
    else if (x > hi) clamp = hi;
    else             clamp = x;
  endfunction

  function automatic logic signed [WIDTH-1:0] hsig(input logic signed [WIDTH-1:0] x);
    hsig = clamp((x >>> 2) + HALF, ZERO, ONE);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = ACC;
      ACC:     if (i_valid && cnt == LAST) next_state = ACT;
      ACT:     next_state = CELL;
      CELL:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == ACC);
    o_busy  = (state != IDLE);
    o_valid = (state == DONE);
  end

  // The new cell state feeds h directly so c and h land in the same CELL edge.
  always_comb begin
    c_new = add_w(mul_q(gate[0], gate[1]), mul_q(gate[2], c_prev));
    h_new = mul_q(clamp(c_new, NEG_ONE, ONE), gate[3]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < 4; g++) begin
        acc[g]  <= '0;
        gate[g] <= '0;
      end
      cnt    <= '0;
      c_prev <= '0;
      o_c    <= '0;
      o_h    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_clr_state) c_prev <= '0;
          if (i_start) begin
            for (int g = 0; g < 4; g++) acc[g] <= i_b[(3-g)*WIDTH +: WIDTH];
            cnt <= '0;
          end
        end
        ACC: begin
          if (i_valid) begin
            for (int g = 0; g < 4; g++)
              acc[g] <= add_w(acc[g], mul_q(i_data, i_w[(3-g)*WIDTH +: WIDTH]));
            cnt <= cnt + 1'b1;
          end
        end
        ACT: begin
          gate[0] <= clamp(acc[0], NEG_ONE, ONE);
          for (int g = 1; g < 4; g++) gate[g] <= hsig(acc[g]);
        end
        CELL: begin
          c_prev <= c_new;
          o_c    <= c_new;
          o_h    <= h_new;
        end
        default: ;
      endcase
    end
  end

  assign o_gate = {gate[0], gate[1], gate[2], gate[3]};

endmodule

// File: tb/tb_lstm_cell_seq.sv
// Directed bench for lstm_cell_seq with NUM_X=NUM_H=1 and Q8.24 data.
module tb_lstm_cell_seq;

  localparam int WIDTH = 32;
  localparam logic [31:0] ONE = 32'h0100_0000;
  localparam logic [127:0] B19 = {32'h0100_0000, 32'h0200_0000, 32'h0200_0000, 32'h0200_0000};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_start = 1'b0;
  logic         i_clr_state = 1'b0;
  logic         i_valid = 1'b0;
  logic [31:0]  i_data = '0;
  logic [127:0] i_w = '0;
  logic [127:0] i_b = '0;
  logic         o_ready, o_busy, o_valid;
  logic [127:0] o_gate;
  logic [31:0]  o_c, o_h;

  int tests = 0;
  int fails = 0;
  int accept_cnt = 0;
  int valid_cnt = 0;
  int lat;
  logic [31:0] a_exp, c_exp, h_exp;

  lstm_cell_seq #(.WIDTH(32), .FRAC(24), .NUM_X(1), .NUM_H(1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_clr_state(i_clr_state),
    .i_valid(i_valid), .i_data(i_data), .i_w(i_w), .i_b(i_b),
    .o_ready(o_ready), .o_busy(o_busy), .o_valid(o_valid),
    .o_gate(o_gate), .o_c(o_c), .o_h(o_h)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_valid && o_ready) accept_cnt++;
    if (o_valid) valid_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One timestep: x then h element back to back; returns cycles from last accept to o_valid.
  task automatic applyStimulus(input logic clr, input logic [127:0] b,
                               input logic [31:0] x, input logic [127:0] wx,
                               input logic [31:0] hh, input logic [127:0] wh,
                               output int latency);
    @(negedge clk);
    i_start = 1'b1; i_clr_state = clr; i_b = b;
    @(negedge clk);
    i_start = 1'b0; i_clr_state = 1'b0;
    checkOutput("ready_in_acc", {127'd0, o_ready}, 128'd1);
    i_valid = 1'b1; i_data = x; i_w = wx;
    @(negedge clk);
    i_data = hh; i_w = wh;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    latency = 1;
    while (!o_valid && latency < 10) begin
      @(posedge clk);
      @(negedge clk);
      latency++;
    end
  endtask

  initial begin
    #3;
    checkOutput("rst_gate", o_gate, 128'd0);
    checkOutput("rst_c", {96'd0, o_c}, 128'd0);
    checkOutput("rst_h", {96'd0, o_h}, 128'd0);
    checkOutput("rst_flags", {125'd0, o_valid, o_ready, o_busy}, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    valid_cnt = 0;
    applyStimulus(1'b1, B19, ONE, '0, ONE, '0, lat);
    checkOutput("t1_latency", 128'(lat), 128'd3);
    checkOutput("t1_gate", o_gate, {ONE, ONE, ONE, ONE});
    checkOutput("t1_c", {96'd0, o_c}, {96'd0, ONE});
    checkOutput("t1_h", {96'd0, o_h}, {96'd0, ONE});

    applyStimulus(1'b0, B19, ONE, '0, ONE, '0, lat);
    checkOutput("t2_latency", 128'(lat), 128'd3);
    checkOutput("t2_c", {96'd0, o_c}, {96'd0, 32'h0200_0000});
    checkOutput("t2_h", {96'd0, o_h}, {96'd0, ONE});
    repeat (3) @(negedge clk);
    checkOutput("t2_hold_c", {96'd0, o_c}, {96'd0, 32'h0200_0000});
    checkOutput("t2_hold_gate", o_gate, {ONE, ONE, ONE, ONE});
    checkOutput("t2_valid_count", 128'(valid_cnt), 128'd2);

`ifdef LSTM_CELL_SEQ_SAT_EN
    a_exp = 32'h0100_0000; c_exp = 32'h0080_0000; h_exp = 32'h0040_0000;
`else
    a_exp = 32'hFF00_0000; c_exp = 32'hFF80_0000; h_exp = 32'hFFC0_0000;
`endif
    applyStimulus(1'b1, {32'h7F00_0000, 96'd0}, 32'h0200_0000, {ONE, 96'd0}, '0, '0, lat);
    checkOutput("t3_gate", o_gate, {a_exp, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000});
    checkOutput("t3_c", {96'd0, o_c}, {96'd0, c_exp});
    checkOutput("t3_h", {96'd0, o_h}, {96'd0, h_exp});

    applyStimulus(1'b1, '0, 32'h0080_0000,
                  {32'h0100_0000, 32'h0200_0000, 32'hFC00_0000, 32'h0400_0000},
                  ONE, {32'h0040_0000, 96'd0}, lat);
    checkOutput("t4_gate", o_gate, {32'h00C0_0000, 32'h00C0_0000, 32'h0000_0000, ONE});
    checkOutput("t4_c", {96'd0, o_c}, {96'd0, 32'h0090_0000});
    checkOutput("t4_h", {96'd0, o_h}, {96'd0, 32'h0090_0000});

    applyStimulus(1'b0, {32'hFD00_0000, 32'h0000_0000, 32'h0400_0000, 32'hFC00_0000},
                  '0, '0, '0, '0, lat);
    checkOutput("t5_gate", o_gate, {32'hFF00_0000, 32'h0080_0000, ONE, 32'h0000_0000});
    checkOutput("t5_c", {96'd0, o_c}, {96'd0, 32'h0010_0000});
    checkOutput("t5_h", {96'd0, o_h}, 128'd0);

    // Stalls on i_valid plus stray start pulses while busy.
    begin
      logic [7:0] st_seq, vl_seq;
      st_seq = 8'b0100_1011;
      vl_seq = 8'b1110_0100;
      repeat (2) @(negedge clk);
      accept_cnt = 0; valid_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        i_start = st_seq[k]; i_valid = vl_seq[k]; i_clr_state = (k == 0);
        i_b = B19; i_w = '0; i_data = ONE;
      end
      @(negedge clk);
      i_start = 1'b0; i_valid = 1'b0; i_clr_state = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("t6_accepts", 128'(accept_cnt), 128'd2);
      checkOutput("t6_valids", 128'(valid_cnt), 128'd1);
      checkOutput("t6_c", {96'd0, o_c}, {96'd0, ONE});
      checkOutput("t6_busy", {127'd0, o_busy}, 128'd0);
    end

    // Reset in the middle of accumulation.
    valid_cnt = 0;
    @(negedge clk);
    i_start = 1'b1; i_b = B19;
    @(negedge clk);
    i_start = 1'b0; i_valid = 1'b1; i_data = ONE; i_w = '0;
    @(negedge clk);
    i_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("t7_rst_flags", {125'd0, o_valid, o_ready, o_busy}, 128'd0);
    checkOutput("t7_rst_c", {96'd0, o_c}, 128'd0);
    checkOutput("t7_rst_gate", o_gate, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t7_idle_after", {127'd0, o_busy}, 128'd0);
    checkOutput("t7_no_valid", 128'(valid_cnt), 128'd0);
    applyStimulus(1'b0, B19, ONE, '0, ONE, '0, lat);
    checkOutput("t7_latency", 128'(lat), 128'd3);
    checkOutput("t7_c", {96'd0, o_c}, {96'd0, ONE});
    checkOutput("t7_h", {96'd0, o_h}, {96'd0, ONE});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
